// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin arbiter sharing one SPI master between NUM_REQ requesters
// Latches the winner's word, drives the active-low start/busy handshake and routes the rx word back.
module spi_req_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int START_TO = 8
) (
  input  logic                      CLOCK_50,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      active,
  output logic [IDX_W-1:0]          cur_idx,
  output logic                      spi_start_n,
  input  logic                      spi_busy,
  output logic [DATA_W-1:0]         spi_tx,
  input  logic [DATA_W-1:0]         spi_rx
);

  localparam int CNT_W = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_DONE} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_W-1:0]    r_tx;
  logic [DATA_W-1:0]    r_rsp;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [NUM_REQ-1:0]   r_err;
  logic                 r_active;
  logic                 r_start_n;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_last_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_W-1:0]    w_tx_nxt;
  logic [DATA_W-1:0]    w_rsp_nxt;
  logic [NUM_REQ-1:0]   w_gnt_nxt;
  logic [NUM_REQ-1:0]   w_done_nxt;
  logic [NUM_REQ-1:0]   w_err_nxt;
  logic                 w_active_nxt;
  logic                 w_start_n_nxt;

  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W:0]       w_base;
  logic [IDX_W:0]       w_off;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W-1:0]     w_win;
  logic [DATA_W-1:0]    w_win_data;

  assign w_req2 = {req, req};

  // Rotate the request vector so the search starts at last+1, then map the offset back.
  always_comb begin
    w_base = {1'b0, r_last} + {{IDX_W{1'b0}}, 1'b1};
    if (w_base >= NUM_EXT) w_base = '0;
    w_rot = w_req2[w_base +: NUM_REQ];
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = (IDX_W + 1)'(k);
    end
    w_sum = w_base + w_off;
    if (w_sum >= NUM_EXT) w_sum = w_sum - NUM_EXT;
    w_win = w_sum[IDX_W-1:0];
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == IDX_W'(k)) w_win_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_last_nxt    = r_last;
    w_idx_nxt     = r_idx;
    w_tx_nxt      = r_tx;
    w_rsp_nxt     = r_rsp;
    w_gnt_nxt     = '0;
    w_done_nxt    = '0;
    w_err_nxt     = '0;
    w_active_nxt  = r_active;
    w_start_n_nxt = r_start_n;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_tx_nxt      = w_win_data;
          w_idx_nxt     = w_win;
          w_gnt_nxt     = NUM_REQ'(1) << w_win;
          w_active_nxt  = 1'b1;
          w_start_n_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        if (spi_busy) begin
          w_start_n_nxt = 1'b1;
          w_state_nxt   = S_XFER;
        end else if (r_cnt == CNT_LAST) begin
          w_start_n_nxt = 1'b1;
          w_err_nxt     = NUM_REQ'(1) << r_idx;
          w_active_nxt  = 1'b0;
          w_last_nxt    = r_idx;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_XFER: begin
        // The master updates data_out on the edge busy falls, so spi_rx is valid here.
        if (!spi_busy) begin
          w_rsp_nxt   = spi_rx;
          w_done_nxt  = NUM_REQ'(1) << r_idx;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_last_nxt   = r_idx;
        w_active_nxt = 1'b0;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_idx     <= '0;
      r_tx      <= '0;
      r_rsp     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_active  <= 1'b0;
      r_start_n <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_idx     <= w_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_rsp     <= w_rsp_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_active  <= w_active_nxt;
      r_start_n <= w_start_n_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign err         = r_err;
  assign rsp_data    = r_rsp;
  assign active      = r_active;
  assign cur_idx     = r_idx;
  assign spi_start_n = r_start_n;
  assign spi_tx      = r_tx;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - scoreboard bench for spi_req_arbiter with a behavioural SPI master
// Words with tx[15:13]==3'b111 are never answered by the master, forcing a start timeout.
module tb_spi_req_arbiter;
  localparam int NUM_REQ  = 3;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = $clog2(NUM_REQ);
  localparam int START_TO = 8;
  localparam logic [DATA_W-1:0] RX_XOR = 16'hDEAD ^ 16'hBEEF;

  logic                      CLOCK_50;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt, done, err;
  logic [DATA_W-1:0]         rsp_data;
  logic                      active;
  logic [IDX_W-1:0]          cur_idx;
  logic                      spi_start_n;
  logic                      spi_busy;
  logic [DATA_W-1:0]         spi_tx;
  logic [DATA_W-1:0]         spi_rx;

  spi_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W), .START_TO(START_TO)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data), .active(active),
    .cur_idx(cur_idx), .spi_start_n(spi_start_n), .spi_busy(spi_busy),
    .spi_tx(spi_tx), .spi_rx(spi_rx)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    bit                is_err;
    int                low;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] words_q [NUM_REQ][$];
  int                m_last;
  int                checks;
  int                failures;

  function automatic int lat_of(input logic [DATA_W-1:0] w);
    return (w[1:0] == 2'd0) ? 1 : int'(w[1:0]);
  endfunction

  function automatic bit is_to(input logic [DATA_W-1:0] w);
    return w[15:13] == 3'b111;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Master model: busy rises lat_of(tx) sampled low-start edges later, lasts 1..4 cycles.
  int m_k, m_len;
  bit m_busy_st;
  always @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy  <= 1'b0;
      spi_rx    <= '0;
      m_k       <= 0;
      m_len     <= 0;
      m_busy_st <= 1'b0;
    end else if (!m_busy_st) begin
      if (!spi_start_n && !is_to(spi_tx)) begin
        if (m_k + 1 >= lat_of(spi_tx)) begin
          spi_busy  <= 1'b1;
          m_busy_st <= 1'b1;
          m_len     <= int'($urandom_range(1, 4));
          m_k       <= 0;
        end else begin
          m_k <= m_k + 1;
        end
      end else begin
        m_k <= 0;
      end
    end else if (m_len <= 1) begin
      spi_busy  <= 1'b0;
      spi_rx    <= spi_tx ^ RX_XOR;
      m_busy_st <= 1'b0;
    end else begin
      m_len <= m_len - 1;
    end
  end

  // Reference: every queued word is pending from phase start; serve round-robin from m_last.
  task automatic model_push();
    int   pos [NUM_REQ];
    int   left;
    exp_t e;
    left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0;
      left += words_q[i].size();
    end
    while (left > 0) begin
      int j;
      j = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (j < 0 && pos[c] < words_q[c].size()) j = c;
      end
      e.idx    = j;
      e.tx     = words_q[j][pos[j]];
      e.is_err = is_to(e.tx);
      e.rx     = e.tx ^ RX_XOR;
      e.low    = e.is_err ? START_TO : lat_of(e.tx) + 1;
      exp_q.push_back(e);
      pos[j]++;
      left--;
      m_last = j;
    end
  endtask

  task automatic run_phase(input int budget);
    int cyc;
    bit fin;
    cyc = 0;
    fin = 1'b0;
    model_push();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (words_q[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = words_q[i][0];
      end
    end
    while (!fin && cyc < budget) begin
      @(negedge CLOCK_50);
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i] || err[i]) begin
          if (words_q[i].size() > 0) void'(words_q[i].pop_front());
          if (words_q[i].size() > 0) begin
            req[i] = 1'b1;
            req_data[i*DATA_W +: DATA_W] = words_q[i][0];
          end else begin
            req[i] = 1'b0;
          end
        end else if (gnt[i]) begin
          req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
          if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
        end
      end
      fin = !active;
      for (int i = 0; i < NUM_REQ; i++) if (words_q[i].size() != 0) fin = 1'b0;
    end
    chk("phase_complete", 32'(fin), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start_n"}, 32'(spi_start_n), 32'd1);
    chk({tag, "_spi_tx"}, 32'(spi_tx), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_cur_idx"}, 32'(cur_idx), 32'd0);
  endtask

  // Monitor: pops one expectation per grant and checks the matching done/err.
  exp_t cur;
  bit   inflight;
  int   low_cnt;
  int   gap;
  always @(negedge CLOCK_50) begin
    if (!rst_n) begin
      inflight = 1'b0;
      low_cnt  = 0;
      gap      = 100;
    end else begin
      gap++;
      if (!spi_start_n) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        if (inflight) chk("start_n_low_cycles", 32'(low_cnt), 32'(cur.low));
        low_cnt = 0;
      end
      if ((gnt | done | err) != '0)
        chk("pulse_onehot_exclusive", 32'($countones({gnt, done, err})), 32'd1);
      if (gnt != '0) begin
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          inflight = 1'b1;
          chk("gnt_vec", 32'(gnt), 32'(1 << cur.idx));
          chk("gnt_cur_idx", 32'(cur_idx), 32'(cur.idx));
          chk("gnt_spi_tx", 32'(spi_tx), 32'(cur.tx));
          chk("gnt_active", 32'(active), 32'd1);
          chk("gnt_gap_after_done", 32'(gap >= 2), 32'd1);
        end
      end
      if ((done | err) != '0) begin
        if (!inflight) begin
          chk("resp_unexpected", 32'({done, err}), 32'd0);
        end else begin
          chk("done_vec", 32'(done), cur.is_err ? 32'd0 : 32'(1 << cur.idx));
          chk("err_vec", 32'(err), cur.is_err ? 32'(1 << cur.idx) : 32'd0);
          if (!cur.is_err) begin
            chk("done_rsp_data", 32'(rsp_data), 32'(cur.rx));
            chk("done_spi_tx_held", 32'(spi_tx), 32'(cur.tx));
            chk("done_active", 32'(active), 32'd1);
            gap = 0;
          end
          inflight = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    checks   = 0;
    failures = 0;
    m_last   = NUM_REQ - 1;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge CLOCK_50);

    words_q[0].push_back(16'hDEAD);
    run_phase(200);

    words_q[0].push_back(16'h0A0A);
    words_q[1].push_back(16'h1B1B);
    words_q[1].push_back(16'h1C1C);
    run_phase(300);

    words_q[0].push_back(16'hE123);
    words_q[1].push_back(16'h2345);
    run_phase(300);

    words_q[2].push_back(16'h3C3D);
    run_phase(200);

    for (int i = 0; i < NUM_REQ; i++) begin
      words_q[i].push_back(DATA_W'(16'h0100 * (i + 1) + 1));
      words_q[i].push_back(DATA_W'(16'h0200 * (i + 1) + 2));
    end
    run_phase(600);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int w = 0; w < n; w++) words_q[i].push_back(DATA_W'($urandom));
      end
      run_phase(1500);
    end

    words_q[0].push_back(16'h2221);
    run_phase(200);
    words_q[1].push_back(16'h3331);
    model_push();
    req[1] = 1'b1;
    req_data[1*DATA_W +: DATA_W] = 16'h3331;
    cyc = 0;
    while (!spi_busy && cyc < 100) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    chk("busy_before_reset", 32'(spi_busy), 32'd1);
    @(negedge CLOCK_50);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    m_last = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) words_q[i].delete();
    exp_q.delete();
    req = '0;
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50);
    words_q[0].push_back(16'h4441);
    words_q[2].push_back(16'h5552);
    run_phase(300);

    repeat (5) @(negedge CLOCK_50);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
